// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: controller for a snake body that is stored in an external,
// free-running DEPTH-stage shift register (sr_in -> ... -> sr_out).
// Element i of the body passes sr_out whenever the phase counter equals i.
// A move rewrites the whole ring in one pass:
//   - the new head direction goes in at phase 0;
//   - every other element moves back by one index.
// Optional feature macro: SNAKE_BODY_SCAN_EN adds a registered element stream
// on scan_valid / scan_index / scan_data. When the macro is undefined, those
// outputs are tied to 0.
module snake_body_ctrl #(
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 234,
  parameter int INIT_LEN = 3,
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sr_out,
  output logic [WIDTH-1:0] sr_in,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [WIDTH-1:0] move_dir,
  input  logic             move_grow,
  output logic             move_done,
  output logic             tail_valid,
  output logic [WIDTH-1:0] tail_dir,
  output logic [LW-1:0]    length,
  output logic             full,
  output logic             scan_valid,
  output logic [PW-1:0]    scan_index,
  output logic [WIDTH-1:0] scan_data
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ALIGN = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic             grow_q, grow_d;
  logic [LW-1:0]    length_q, length_d;
  logic             move_done_q, move_done_d;
  logic             tail_valid_q, tail_valid_d;
  logic [WIDTH-1:0] tail_dir_q, tail_dir_d;

  logic p_last_s;
  logic full_s;
  logic accept_s;
  logic shift_last_s;
  logic tail_hit_s;

  assign p_last_s     = (p_q == PW'(DEPTH - 1));
  assign full_s       = (length_q == LW'(DEPTH));
  assign accept_s     = (state_q == ST_IDLE) && move_valid;
  assign shift_last_s = (state_q == ST_SHIFT) && p_last_s;
  // The tail leaves the body unless the move actually grows it (saturated growth drops).
  assign tail_hit_s   = (state_q == ST_SHIFT) && (!grow_q || full_s) &&
                        (LW'(p_q) == (length_q - LW'(1)));

  assign move_done  = move_done_q;
  assign tail_valid = tail_valid_q;
  assign tail_dir   = tail_dir_q;
  assign length     = length_q;
  assign full       = full_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      p_q          <= {PW{1'b0}};
      hold_q       <= {WIDTH{1'b0}};
      dir_q        <= {WIDTH{1'b0}};
      grow_q       <= 1'b0;
      length_q     <= LW'(INIT_LEN);
      move_done_q  <= 1'b0;
      tail_valid_q <= 1'b0;
      tail_dir_q   <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      hold_q       <= hold_d;
      dir_q        <= dir_d;
      grow_q       <= grow_d;
      length_q     <= length_d;
      move_done_q  <= move_done_d;
      tail_valid_q <= tail_valid_d;
      tail_dir_q   <= tail_dir_d;
    end
  end

  // Next-state logic: every pass boundary is the phase DEPTH-1 cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (p_last_s) state_d = ST_IDLE; else state_d = ST_INIT;
      ST_IDLE: begin
        if (move_valid) begin
          if (p_last_s) state_d = ST_SHIFT; else state_d = ST_ALIGN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALIGN: if (p_last_s) state_d = ST_SHIFT; else state_d = ST_ALIGN;
      ST_SHIFT: if (p_last_s) state_d = ST_IDLE;  else state_d = ST_SHIFT;
      default:  state_d = ST_INIT;
    endcase
  end

  // Ring input and handshake: clear, recirculate, or shift back by one element.
  always_comb begin
    sr_in      = {WIDTH{1'b0}};
    move_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        sr_in      = {WIDTH{1'b0}};
        move_ready = 1'b0;
      end
      ST_IDLE: begin
        sr_in      = sr_out;
        move_ready = 1'b1;
      end
      ST_ALIGN: begin
        sr_in      = sr_out;
        move_ready = 1'b0;
      end
      ST_SHIFT: begin
        if (p_q == {PW{1'b0}}) sr_in = dir_q; else sr_in = hold_q;
        move_ready = 1'b0;
      end
      default: begin
        sr_in      = {WIDTH{1'b0}};
        move_ready = 1'b0;
      end
    endcase
  end

  // Phase counter, move latches, length update and the done/tail pulses.
  always_comb begin
    if (p_last_s) p_d = {PW{1'b0}}; else p_d = p_q + PW'(1);
    if (state_q == ST_SHIFT) hold_d = sr_out; else hold_d = hold_q;
    if (accept_s) begin
      dir_d  = move_dir;
      grow_d = move_grow;
    end else begin
      dir_d  = dir_q;
      grow_d = grow_q;
    end
    if (shift_last_s && grow_q && !full_s) length_d = length_q + LW'(1);
    else length_d = length_q;
    move_done_d  = shift_last_s;
    tail_valid_d = tail_hit_s;
    if (tail_hit_s) tail_dir_d = sr_out; else tail_dir_d = tail_dir_q;
  end

`ifdef SNAKE_BODY_SCAN_EN
  logic             scan_valid_q, scan_valid_d;
  logic [PW-1:0]    scan_index_q, scan_index_d;
  logic [WIDTH-1:0] scan_data_q, scan_data_d;

  assign scan_valid = scan_valid_q;
  assign scan_index = scan_index_q;
  assign scan_data  = scan_data_q;

  // Element stream: one element per cycle, tagged valid while inside the body.
  always_comb begin
    if (state_q == ST_INIT) begin
      scan_valid_d = 1'b0;
      scan_index_d = {PW{1'b0}};
      scan_data_d  = {WIDTH{1'b0}};
    end else begin
      scan_valid_d = (LW'(p_q) < length_q);
      scan_index_d = p_q;
      scan_data_d  = sr_out;
    end
  end

  // Scan output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_valid_q <= 1'b0;
      scan_index_q <= {PW{1'b0}};
      scan_data_q  <= {WIDTH{1'b0}};
    end else begin
      scan_valid_q <= scan_valid_d;
      scan_index_q <= scan_index_d;
      scan_data_q  <= scan_data_d;
    end
  end
`else
  assign scan_valid = 1'b0;
  assign scan_index = {PW{1'b0}};
  assign scan_data  = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl (DEPTH=8, INIT_LEN=3) with a behavioural ring model
// and a body reference kept as a queue of directions (head first).
module tb_snake_body_ctrl;
  localparam int WIDTH    = 2;
  localparam int DEPTH    = 8;
  localparam int INIT_LEN = 3;
  localparam int PW       = 3;
  localparam int LW       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sr_out, sr_in, move_dir, tail_dir, scan_data;
  logic             move_valid, move_ready, move_grow, move_done, tail_valid, full, scan_valid;
  logic [LW-1:0]    length;
  logic [PW-1:0]    scan_index;

  logic [WIDTH-1:0] sr [DEPTH];
  bit               scramble;
  int               cyc;
  int               npass = 0;
  int               ntotal = 0;
  int               q[$];

  typedef struct {
    logic [WIDTH-1:0] dir;
    bit               grow;
    int               exp_len;
    int               exp_tcnt;
    int               exp_tdir;
    int               exp_el[DEPTH];
  } vec_t;
  vec_t tbl[6];

  snake_body_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_LEN(INIT_LEN)) dut (
    .clk(clk), .rst(rst), .sr_out(sr_out), .sr_in(sr_in),
    .move_valid(move_valid), .move_ready(move_ready), .move_dir(move_dir),
    .move_grow(move_grow), .move_done(move_done), .tail_valid(tail_valid),
    .tail_dir(tail_dir), .length(length), .full(full), .scan_valid(scan_valid),
    .scan_index(scan_index), .scan_data(scan_data)
  );

  always #5 clk = ~clk;

  // External shift register (no reset) plus cycle count since reset.
  assign sr_out = sr[DEPTH-1];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= 2'($urandom);
    end else begin
      for (int i = DEPTH-1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= sr_in;
    end
    if (rst) cyc <= 0; else cyc <= cyc + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Logical element e as stored in the ring right now (ring sits at phase cyc%DEPTH).
  function automatic int elem(input int e);
    int idx;
    idx = (e - (cyc % DEPTH) + DEPTH) % DEPTH;
    return int'(sr[DEPTH-1-idx]);
  endfunction

  task automatic reset_dut();
    rst = 1'b1; move_valid = 1'b0; move_dir = 2'd0; move_grow = 1'b0;
    @(negedge clk);
    check("rst_ready", move_ready, 0);
    check("rst_done", move_done, 0);
    check("rst_tail_valid", tail_valid, 0);
    check("rst_tail_dir", tail_dir, 0);
    check("rst_length", length, INIT_LEN);
    check("rst_full", full, 0);
    check("rst_sr_in", sr_in, 0);
    check("rst_scan", {scan_valid, scan_index, scan_data}, 0);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check("init_ready", move_ready, 0);
      check("init_done", move_done, 0);
      @(negedge clk);
    end
    check("ready_after_init", move_ready, 1);
    check("len_after_init", length, INIT_LEN);
    q.delete();
    for (int i = 0; i < INIT_LEN; i++) q.push_back(0);
  endtask

  task automatic do_move(input logic [WIDTH-1:0] dir, input bit grow, input bit at_last,
                         output int lat, output int tcnt, output int tdir);
    int guard;
    guard = 0;
    while ((!move_ready || (at_last && (cyc % DEPTH) != DEPTH-1)) && guard < 4*DEPTH) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait_bound", int'(guard < 4*DEPTH), 1);
    move_valid = 1'b1; move_dir = dir; move_grow = grow;
    lat = 0; tcnt = 0; tdir = 0;
    do begin
      @(negedge clk);
      lat++;
      if (tail_valid) begin tcnt++; tdir = int'(tail_dir); end
      // Requests while busy must be ignored.
      move_valid = 1'($urandom); move_dir = 2'($urandom); move_grow = 1'($urandom);
      if (move_done) move_valid = 1'b0;
    end while (!move_done && lat < 2*DEPTH + 2);
    move_valid = 1'b0;
    check("done_seen", move_done, 1);
  endtask

  task automatic model_move(input logic [WIDTH-1:0] dir, input bit grow, input bit at_last);
    int lat, tcnt, tdir, exp_tcnt, exp_tdir;
    exp_tcnt = 0; exp_tdir = 0;
    if (!(grow && q.size() < DEPTH)) begin
      exp_tcnt = 1;
      exp_tdir = q[$];
      void'(q.pop_back());
    end
    q.push_front(int'(dir));
    do_move(dir, grow, at_last, lat, tcnt, tdir);
    check("lat_range", int'(lat >= DEPTH+1 && lat <= 2*DEPTH+1), 1);
    if (at_last) check("lat_exact", lat, DEPTH+1);
    check("tail_count", tcnt, exp_tcnt);
    if (exp_tcnt == 1) check("tail_dir", tdir, exp_tdir);
    check("length", length, q.size());
    check("full", full, int'(q.size() == DEPTH));
    for (int i = 0; i < q.size(); i++) check("elem", elem(i), q[i]);
  endtask

  task automatic scan_window();
    for (int k = 0; k < DEPTH + 1; k++) begin
      @(negedge clk);
`ifdef SNAKE_BODY_SCAN_EN
      begin
        int pp;
        pp = (cyc + DEPTH - 1) % DEPTH;
        check("scan_valid", scan_valid, int'(pp < q.size()));
        check("scan_index", scan_index, pp);
        if (pp < q.size()) check("scan_data", scan_data, q[pp]);
      end
`else
      check("scan_off", {scan_valid, scan_index, scan_data}, 0);
`endif
    end
  endtask

  task automatic set_vec(input int i, input int dir, input bit grow, input int len,
                         input int tcnt, input int tdir, input int e0, input int e1,
                         input int e2, input int e3, input int e4);
    tbl[i].dir = 2'(dir); tbl[i].grow = grow; tbl[i].exp_len = len;
    tbl[i].exp_tcnt = tcnt; tbl[i].exp_tdir = tdir;
    tbl[i].exp_el[0] = e0; tbl[i].exp_el[1] = e1; tbl[i].exp_el[2] = e2;
    tbl[i].exp_el[3] = e3; tbl[i].exp_el[4] = e4;
    for (int j = 5; j < DEPTH; j++) tbl[i].exp_el[j] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, tcnt, tdir, g;
    // Directed move table, starting from the post-reset body [0,0,0].
    set_vec(0, 3, 1'b0, 3, 1, 0, 3, 0, 0, 0, 0);
    set_vec(1, 2, 1'b0, 3, 1, 0, 2, 3, 0, 0, 0);
    set_vec(2, 1, 1'b0, 3, 1, 0, 1, 2, 3, 0, 0);
    set_vec(3, 0, 1'b0, 3, 1, 3, 0, 1, 2, 0, 0);
    set_vec(4, 1, 1'b1, 4, 0, 0, 1, 0, 1, 2, 0);
    set_vec(5, 2, 1'b1, 5, 0, 0, 2, 1, 0, 1, 2);

    scramble = 1'b1; rst = 1'b1; move_valid = 1'b0; move_dir = 2'd0; move_grow = 1'b0;
    @(negedge clk);
    scramble = 1'b0;
    reset_dut();
    for (int i = 0; i < DEPTH; i++) check("init_zero", elem(i), 0);

    // Grow accepted at the last phase: done exactly DEPTH+1 cycles later.
    model_move(2'd2, 1'b1, 1'b1);
    check("req036_len", length, 4);
    for (int i = 0; i < 4; i++) check("req036_elem", elem(i), (i == 0) ? 2 : 0);

    reset_dut();
    for (int i = 0; i < 6; i++) begin
      do_move(tbl[i].dir, tbl[i].grow, 1'($urandom), lat, tcnt, tdir);
      check("tbl_lat", int'(lat >= DEPTH+1 && lat <= 2*DEPTH+1), 1);
      check("tbl_len", length, tbl[i].exp_len);
      check("tbl_tcnt", tcnt, tbl[i].exp_tcnt);
      if (tbl[i].exp_tcnt == 1) check("tbl_tdir", tdir, tbl[i].exp_tdir);
      for (int j = 0; j < tbl[i].exp_len; j++) check("tbl_elem", elem(j), tbl[i].exp_el[j]);
    end
    q.delete();
    for (int j = 0; j < tbl[5].exp_len; j++) q.push_back(tbl[5].exp_el[j]);
    scan_window();

    // Randomized moves against the queue model.
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model_move(2'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
    end
    g = 0;
    while (q.size() < DEPTH && g < 2*DEPTH) begin
      model_move(2'($urandom), 1'b1, 1'b0);
      g++;
    end
    check("reached_full", full, 1);
    // Saturated growth drops old element DEPTH-1.
    tdir = q[DEPTH-1];
    do_move(2'd1, 1'b1, 1'b0, lat, tcnt, g);
    check("sat_len", length, DEPTH);
    check("sat_tail_count", tcnt, 1);
    check("sat_tail_dir", g, tdir);
    void'(q.pop_back());
    q.push_front(1);
    for (int i = 0; i < DEPTH; i++) check("sat_elem", elem(i), q[i]);
    scan_window();

    // Reset in the middle of a shift pass abandons the move.
    g = 0;
    while (!(move_ready && (cyc % DEPTH) == DEPTH-1) && g < 4*DEPTH) begin
      @(negedge clk);
      g++;
    end
    move_valid = 1'b1; move_dir = 2'd3; move_grow = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      move_valid = 1'b0;
      check("mid_no_done", move_done, 0);
    end
    reset_dut();
    for (int i = 0; i < DEPTH; i++) check("reinit_zero", elem(i), 0);
    model_move(2'd3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/snake_body_ctrl.md
SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 2, bits per body element (direction code).
REQ-002 SHALL have parameter DEPTH, default 234, number of stages in the attached free-running shift register.
REQ-003 SHALL have parameter INIT_LEN, default 3, body length after reset (1..DEPTH).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 sr_out  in  WIDTH  shift register tail output.
REQ-007 sr_in  out  WIDTH  shift register head input.
REQ-008 move_valid  in  1  move request.
REQ-009 move_ready  out  1  controller can accept a move.
REQ-010 move_dir  in  WIDTH  new head direction, sampled on accept.
REQ-011 move_grow  in  1  grow by one element instead of dropping the tail, sampled on accept.
REQ-012 move_done  out  1  one-cycle pulse when the move pass completes.
REQ-013 tail_valid / tail_dir  out  1 / WIDTH  dropped tail element, one-cycle pulse.
REQ-014 length  out  clog2(DEPTH+1)  current body length.
REQ-015 full  out  1  length == DEPTH.
REQ-016 scan_valid / scan_index / scan_data  out  1 / clog2(DEPTH) / WIDTH  element stream (see Configuration).

Function
REQ-017 Phase counter p SHALL count 0..DEPTH-1 every cycle and wrap to 0; at p==0 sr_out carries logical element 0 (head).
REQ-018 FSM states: INIT, IDLE, ALIGN, SHIFT.
REQ-019 INIT: sr_in=0 for one full pass (p 0..DEPTH-1); move_ready=0; -> IDLE after p==DEPTH-1.
REQ-020 IDLE: sr_in=sr_out (recirculate); move_ready=1; on move_valid&&move_ready latch dir/grow -> ALIGN.
REQ-021 ALIGN: recirculate; move_ready=0; -> SHIFT on cycle with p==DEPTH-1 (including acceptance cycle if p==DEPTH-1).
REQ-022 SHIFT, p==0: sr_in=latched dir, hold<=sr_out; p>=1: sr_in=hold, hold<=sr_out; one pass then -> IDLE.
REQ-023 On last SHIFT cycle (p==DEPTH-1) SHALL update length and raise move_done the following cycle, together with the first IDLE cycle.
REQ-024 grow=1 and length<DEPTH: length+1, no tail_valid.
REQ-025 grow=1 and length==DEPTH: length unchanged (saturate), tail dropped as for grow=0.
REQ-026 grow=0: tail_valid pulses with tail_dir = old element length-1, captured from sr_out when p==length-1 during SHIFT, pulse on the following cycle.
REQ-027 Elements at index >= length SHALL be don't-care; only indices < length are defined.
REQ-028 Move latency: accept to move_done <= 2*DEPTH+1 cycles; minimum DEPTH+1.
REQ-029 move_valid while move_ready=0 SHALL be ignored (no queuing).

Reset
REQ-030 rst SHALL take priority over all inputs in the same cycle, mid-SHIFT included, abandoning any move without move_done.
REQ-031 Reset values: state INIT, p=0, hold=0, length=INIT_LEN, move_ready=0, move_done=0, tail_valid=0, tail_dir=0, sr_in=0, scan_* = 0.
REQ-032 Shift register has no reset; INIT pass SHALL establish all elements = 0.

Configuration
REQ-033 Macro SNAKE_BODY_SCAN_EN defined: every cycle outside INIT, scan_valid=(p<length), scan_index=p, scan_data=sr_out, registered one cycle.
REQ-034 Macro undefined: scan_valid, scan_index, scan_data SHALL be constant 0 and no scan logic is synthesized.

Verification
REQ-035 DEPTH=8, INIT_LEN=3: rst 1 cycle -> move_ready=0 for 8 cycles, then 1; length=3; all elements read 0.
REQ-036 IDLE, move dir=2 grow=1 accepted at p==7 -> move_done 9 cycles later, length=4, elements [2,0,0,0], no tail_valid.
REQ-037 Elements [1,2,3], move dir=0 grow=0 -> tail_valid with tail_dir=3, length=3, elements [0,1,2].
REQ-038 length=8 (full=1), move grow=1 -> length stays 8, tail_valid fires with old element 7.
REQ-039 rst asserted at SHIFT p==4 -> no move_done, next cycle state INIT, length=INIT_LEN, move_ready=0.
REQ-040 SNAKE_BODY_SCAN_EN defined, length=3 -> per pass scan_valid high for indices 0,1,2 with correct data; undefined -> scan_* stay 0.
